// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Single gate shared by an entry lane and an exit lane. A four-state FSM
//   (IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSING) opens the gate for one vehicle at
//   a time, round-robins between the lanes when both are waiting, tracks the
//   parked count and closes on pass_done or on an open-gate timeout.
//
//   Optional feature: define GATE_FLASH_EN to build the warning-lamp divider.
//   Without it, flash is tied low and no divider exists.
//
//   Handshake: entry_req/exit_req are levels, sampled only in IDLE; a grant
//   is the one-cycle grant_entry/grant_exit pulse on the first open cycle.
//   pass_done is a one-cycle pulse honoured only in an OPEN state.
//
//   All outputs come straight from flops. Each flop <sig>_q is loaded from
//   <sig>_d, which is computed from the next state so outputs line up with
//   the state they describe.
module parking_gate_arbiter #(
  parameter int CAPACITY    = 40,
  parameter int CNT_W       = 6,
  parameter int OPEN_TICKS  = 10000000,
  parameter int CLOSE_TICKS = 1000000,
  parameter int FLASH_DIV   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_done,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             timeout,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             flash
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSING    = 2'd3
  } state_t;

  // One shared tick counter serves both the open timeout and the close guard.
  localparam int TICK_MAX = (OPEN_TICKS > CLOSE_TICKS) ? OPEN_TICKS : CLOSE_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TICK_W-1:0] OPEN_LAST  = TICK_W'(OPEN_TICKS - 1);
  localparam logic [TICK_W-1:0] CLOSE_LAST = TICK_W'(CLOSE_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
  localparam logic [CNT_W-1:0]  CAP        = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0]  OCC_ONE    = CNT_W'(1);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              last_exit_q, last_exit_d;  // 1: exit lane won the last grant
  logic              gate_open_q, gate_open_d;
  logic              grant_entry_q, grant_entry_d;
  logic              grant_exit_q, grant_exit_d;
  logic              timeout_q, timeout_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              busy_q, busy_d;

  logic entry_ok;
  logic exit_ok;

  // A lane is only eligible if serving it cannot push occupancy out of range.
  assign entry_ok = entry_req & ~full_q;
  assign exit_ok  = exit_req & ~empty_q;

  // Next-state, counter, occupancy and registered-output computation.
  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q + TICK_ONE;
    occ_d         = occ_q;
    last_exit_d   = last_exit_q;
    grant_entry_d = 1'b0;
    grant_exit_d  = 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        // On a tie, the lane that did not win last time goes first.
        if (entry_ok && (!exit_ok || last_exit_q)) begin
          state_d       = ENTRY_OPEN;
          grant_entry_d = 1'b1;
          last_exit_d   = 1'b0;
        end else if (exit_ok) begin
          state_d      = EXIT_OPEN;
          grant_exit_d = 1'b1;
          last_exit_d  = 1'b1;
        end
      end

      ENTRY_OPEN, EXIT_OPEN: begin
        // pass_done takes priority over a timeout landing on the same cycle.
        if (pass_done) begin
          state_d = CLOSING;
          tick_d  = '0;
          if (state_q == ENTRY_OPEN) begin
            if (occ_q != CAP) occ_d = occ_q + OCC_ONE;
          end else begin
            if (occ_q != '0) occ_d = occ_q - OCC_ONE;
          end
        end else if (tick_q == OPEN_LAST) begin
          state_d   = CLOSING;
          tick_d    = '0;
          timeout_d = 1'b1;
        end
      end

      CLOSING: begin
        if (tick_q == CLOSE_LAST) begin
          state_d = IDLE;
          tick_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase

    gate_open_d = (state_d == ENTRY_OPEN) || (state_d == EXIT_OPEN);
    busy_d      = (state_d != IDLE);
    full_d      = (occ_d == CAP);
    empty_d     = (occ_d == '0);
  end

  // State and output registers; reset closes the gate without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      occ_q         <= '0;
      last_exit_q   <= 1'b1;
      gate_open_q   <= 1'b0;
      grant_entry_q <= 1'b0;
      grant_exit_q  <= 1'b0;
      timeout_q     <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      occ_q         <= occ_d;
      last_exit_q   <= last_exit_d;
      gate_open_q   <= gate_open_d;
      grant_entry_q <= grant_entry_d;
      grant_exit_q  <= grant_exit_d;
      timeout_q     <= timeout_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      busy_q        <= busy_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign grant_entry = grant_entry_q;
  assign grant_exit  = grant_exit_q;
  assign timeout     = timeout_q;
  assign occupancy   = occ_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign busy        = busy_q;

`ifdef GATE_FLASH_EN
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);

  logic               flash_q, flash_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;

  // Lamp is dark in IDLE, lights on the first open cycle, then toggles
  // every FLASH_DIV cycles until the gate has fully closed.
  always_comb begin
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    if (state_d == IDLE) begin
      flash_d     = 1'b0;
      flash_cnt_d = '0;
    end else if (state_q == IDLE) begin
      flash_d     = 1'b1;
      flash_cnt_d = '0;
    end else if (flash_cnt_q == FLASH_LAST) begin
      flash_d     = ~flash_q;
      flash_cnt_d = '0;
    end else begin
      flash_cnt_d = flash_cnt_q + FLASH_ONE;
    end
  end

  // Lamp divider registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter
//   Directed bench for parking_gate_arbiter with small timing parameters
//   (OPEN_TICKS=20, CLOSE_TICKS=4, CAPACITY=3, FLASH_DIV=2). Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
//   Build with or without GATE_FLASH_EN; the expected lamp follows the macro.
module tb_parking_gate_arbiter;

  localparam int CAPACITY    = 3;
  localparam int CNT_W       = 6;
  localparam int OPEN_TICKS  = 20;
  localparam int CLOSE_TICKS = 4;
  localparam int FLASH_DIV   = 2;

  logic             clk;
  logic             reset;
  logic             entry_req;
  logic             exit_req;
  logic             pass_done;
  logic             gate_open;
  logic             grant_entry;
  logic             grant_exit;
  logic             timeout;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             busy;
  logic             flash;

  int checks = 0;
  int errors = 0;

  parking_gate_arbiter #(
    .CAPACITY   (CAPACITY),
    .CNT_W      (CNT_W),
    .OPEN_TICKS (OPEN_TICKS),
    .CLOSE_TICKS(CLOSE_TICKS),
    .FLASH_DIV  (FLASH_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .pass_done  (pass_done),
    .gate_open  (gate_open),
    .grant_entry(grant_entry),
    .grant_exit (grant_exit),
    .timeout    (timeout),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .flash      (flash)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lamp level for the i-th cycle since the gate opened (i=0 first open cycle).
  function automatic logic exp_flash(input int i);
`ifdef GATE_FLASH_EN
    return ((i / FLASH_DIV) % 2) == 0;
`else
    return 1'b0;
`endif
  endfunction

  // One full gate visit. Called in an IDLE cycle with requests already set.
  // pass_at < 0 means no pass_done (timeout path).
  task automatic visit(input string tag, input bit exp_entry, input int pass_at,
                       input int occ_before, input int occ_after);
    int n_open;
    n_open = (pass_at >= 0 && pass_at < OPEN_TICKS) ? pass_at + 1 : OPEN_TICKS;
    tick();
    check({tag, "_grant_entry"}, grant_entry, exp_entry);
    check({tag, "_grant_exit"}, grant_exit, !exp_entry);
    for (int k = 0; k < n_open; k++) begin
      check($sformatf("%s_gate%0d", tag, k), gate_open, 1);
      check($sformatf("%s_busy%0d", tag, k), busy, 1);
      check($sformatf("%s_flash%0d", tag, k), flash, exp_flash(k));
      check($sformatf("%s_occ%0d", tag, k), occupancy, occ_before);
      check($sformatf("%s_timeout%0d", tag, k), timeout, 0);
      if (k > 0) begin
        check($sformatf("%s_grant_hi%0d", tag, k), {grant_entry, grant_exit}, 0);
      end
      pass_done = (k == pass_at);
      tick();
      pass_done = 1'b0;
    end
    check({tag, "_closed"}, gate_open, 0);
    check({tag, "_timeout_pulse"}, timeout, (pass_at < 0) ? 1 : 0);
    check({tag, "_occ_after"}, occupancy, occ_after);
    check({tag, "_full"}, full, (occ_after == CAPACITY) ? 1 : 0);
    check({tag, "_empty"}, empty, (occ_after == 0) ? 1 : 0);
    for (int c = 0; c < CLOSE_TICKS; c++) begin
      if (c > 0) tick();
      check($sformatf("%s_closing%0d", tag, c), {busy, gate_open}, 2'b10);
      check($sformatf("%s_cflash%0d", tag, c), flash, exp_flash(n_open + c));
      if (c > 0) check($sformatf("%s_ctimeout%0d", tag, c), timeout, 0);
    end
    tick();
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_gate"}, gate_open, 0);
    check({tag, "_idle_flash"}, flash, 0);
  endtask

  initial begin
    reset     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    pass_done = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst_gate", gate_open, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {grant_entry, grant_exit, timeout}, 0);
    check("rst_flash", flash, 0);

    // Entry held from reset, vehicle passes on open cycle 5.
    entry_req = 1'b1;
    reset     = 1'b1;
    visit("entry1", 1'b1, 5, 0, 1);
    entry_req = 1'b0;

    // Exit lane opened, nobody passes: timeout, occupancy unchanged.
    exit_req = 1'b1;
    visit("exit_to", 1'b0, -1, 1, 1);

    // Both lanes waiting: alternate entry, exit, entry back-to-back.
    entry_req = 1'b1;
    visit("rr1", 1'b1, 2, 1, 2);
    visit("rr2", 1'b0, 3, 2, 1);
    visit("rr3", 1'b1, 0, 1, 2);
    exit_req = 1'b0;

    // pass_done on the timeout cycle: count changes, no timeout pulse.
    visit("coincide", 1'b1, OPEN_TICKS - 1, 2, 3);

    // Full lot: entry request is not granted.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("full_gate%0d", i), gate_open, 0);
      check($sformatf("full_grant%0d", i), grant_entry, 0);
      check($sformatf("full_busy%0d", i), busy, 0);
      check($sformatf("full_flag%0d", i), full, 1);
      check($sformatf("full_occ%0d", i), occupancy, 3);
    end

    // Free one space, then open for entry and reset mid-open.
    entry_req = 1'b0;
    exit_req  = 1'b1;
    visit("exit2", 1'b0, 1, 3, 2);
    exit_req  = 1'b0;
    entry_req = 1'b1;
    tick();
    check("pre_rst_gate", gate_open, 1);
    check("pre_rst_grant", grant_entry, 1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_gate", gate_open, 0);
    check("async_rst_occ", occupancy, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_flash", flash, 0);
    tick();
    tick();
    check("held_rst_gate", gate_open, 0);

    // Empty lot: exit request is not granted.
    entry_req = 1'b0;
    exit_req  = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("empty_gate%0d", i), gate_open, 0);
      check($sformatf("empty_grant%0d", i), grant_exit, 0);
      check($sformatf("empty_flag%0d", i), empty, 1);
      check($sformatf("empty_busy%0d", i), busy, 0);
    end
    exit_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
